pc_sequencer: RTL and testbench

- Program-counter sequencer for the 8-bit processor core.
- Fetches each instruction through a req/ack handshake with instruction memory.
- Hands the instruction to the decoder/executor through a valid/ready handshake, then waits for the execute-done strobe.
- Resolves the next PC from pc_op and cmp_res; the PC either increments or loads jmp_target.

---
 rtl/cpu_pkg.sv | 42 ++++
 rtl/pc_sequencer_if.sv | 39 +++
 rtl/pc_sequencer_branch_resolve.sv | 24 ++
 rtl/pc_sequencer.sv | 139 +++++++++++++
 tb/tb_pc_sequencer.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit core's program-counter sequencer.
// Contents:
//   PC_OP_*           encodings of the executor's pc_op field
//   CMP_WIDTH         width of the comparator result bus
//   RESET_PC_DEFAULT  default PC loaded on reset
//   seq_state_t       sequencer FSM states
//   branch_take()     decides whether a resolved instruction loads jmp_target
package cpu_pkg;

  localparam logic [1:0] PC_OP_NEXT = 2'd0;  // fall through to pc + 1
  localparam logic [1:0] PC_OP_JMP  = 2'd1;  // unconditional jump
  localparam logic [1:0] PC_OP_JZ   = 2'd2;  // jump if cmp_res == 0
  localparam logic [1:0] PC_OP_JONE = 2'd3;  // jump if cmp_res == 1

  localparam int unsigned CMP_WIDTH        = 8;
  localparam int unsigned RESET_PC_DEFAULT = 0;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    ISSUE  = 3'd2,
    EXEC   = 3'd3,
    HALTED = 3'd4
  } seq_state_t;

  // Conditional ops compare against exact values: JONE needs cmp_res to be
  // precisely 1, not merely non-zero.
  function automatic logic branch_take(input logic [1:0] op,
                                       input logic [CMP_WIDTH-1:0] cmp);
    logic take;
    take = 1'b0;
    case (op)
      PC_OP_NEXT: take = 1'b0;
      PC_OP_JMP:  take = 1'b1;
      PC_OP_JZ:   take = (cmp == CMP_WIDTH'(0));
      PC_OP_JONE: take = (cmp == CMP_WIDTH'(1));
      default:    take = 1'b0;
    endcase
    return take;
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Bus bundle between the PC sequencer and its neighbours.
// Groups three handshakes:
//   instruction memory  imem_req/imem_addr  ->  imem_ack/imem_data
//   decoder issue       instr/instr_valid   ->  instr_ready
//   execute result      exec_done, pc_op, cmp_res, jmp_target
// Modports:
//   master  the sequencer side
//   slave   the memory/decoder/executor side
interface pc_sequencer_if #(
  parameter int unsigned PC_WIDTH    = 8,
  parameter int unsigned INSTR_WIDTH = 16
);
  import cpu_pkg::*;

  logic                   imem_req;
  logic [PC_WIDTH-1:0]    imem_addr;
  logic                   imem_ack;
  logic [INSTR_WIDTH-1:0] imem_data;

  logic [INSTR_WIDTH-1:0] instr;
  logic                   instr_valid;
  logic                   instr_ready;

  logic                   exec_done;
  logic [1:0]             pc_op;
  logic [CMP_WIDTH-1:0]   cmp_res;
  logic [PC_WIDTH-1:0]    jmp_target;

  modport master (
    output imem_req, imem_addr, instr, instr_valid,
    input  imem_ack, imem_data, instr_ready, exec_done, pc_op, cmp_res, jmp_target
  );

  modport slave (
    input  imem_req, imem_addr, instr, instr_valid,
    output imem_ack, imem_data, instr_ready, exec_done, pc_op, cmp_res, jmp_target
  );

endinterface

// File: rtl/pc_sequencer_branch_resolve.sv
// branch_resolve: combinational next-PC selection.
// Inputs : pc, pc_op, cmp_res, jmp_target
// Outputs: take    (1 when the instruction redirects the PC)
//          next_pc (jmp_target when taken, otherwise pc + 1 wrapping mod 2^PC_WIDTH)
module branch_resolve
  import cpu_pkg::*;
#(
  parameter int unsigned PC_WIDTH = 8
) (
  input  logic [PC_WIDTH-1:0]  pc,
  input  logic [1:0]           pc_op,
  input  logic [CMP_WIDTH-1:0] cmp_res,
  input  logic [PC_WIDTH-1:0]  jmp_target,
  output logic [PC_WIDTH-1:0]  next_pc,
  output logic                 take
);

  always_comb begin
    take    = branch_take(pc_op, cmp_res);
    // The increment is truncated to PC_WIDTH, so the top address wraps to 0.
    next_pc = take ? jmp_target : pc + PC_WIDTH'(1);
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer for the 8-bit core.
// Each instruction passes through FETCH (imem req/ack), ISSUE (valid/ready
// to the decoder) and EXEC (wait for exec_done, then resolve the next PC).
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   run           level; while low no new fetch is started
//   halt          pulse; stop after the current instruction completes
//   bus           pc_sequencer_if.master (imem, issue and execute handshakes)
//   pc            current program counter
//   branch_taken  one-cycle pulse when the PC loaded jmp_target
//   halted        high while in HALTED
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned PC_WIDTH    = 8,
  parameter int unsigned INSTR_WIDTH = 16,
  parameter int unsigned RESET_PC    = RESET_PC_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  input  logic                halt,
  pc_sequencer_if.master      bus,
  output logic [PC_WIDTH-1:0] pc,
  output logic                branch_taken,
  output logic                halted
);

  seq_state_t             state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic                   halt_pend_q, halt_pend_d;
  logic                   branch_taken_q, branch_taken_d;

  logic [PC_WIDTH-1:0]    next_pc;
  logic                   take;

  branch_resolve #(
    .PC_WIDTH (PC_WIDTH)
  ) u_branch_resolve (
    .pc         (pc_q),
    .pc_op      (bus.pc_op),
    .cmp_res    (bus.cmp_res),
    .jmp_target (bus.jmp_target),
    .next_pc    (next_pc),
    .take       (take)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      pc_q           <= PC_WIDTH'(RESET_PC);
      instr_q        <= '0;
      halt_pend_q    <= 1'b0;
      branch_taken_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      instr_q        <= instr_d;
      halt_pend_q    <= halt_pend_d;
      branch_taken_q <= branch_taken_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    instr_d        = instr_q;
    halt_pend_d    = halt_pend_q;
    branch_taken_d = 1'b0;

    case (state_q)
      IDLE: begin
        // Halt wins over run so a halted core cannot sneak in one more fetch.
        if (halt) begin
          state_d = HALTED;
        end else if (run) begin
          state_d = FETCH;
        end
      end

      FETCH: begin
        // run dropping here does not cancel the outstanding request.
        halt_pend_d = halt_pend_q | halt;
        if (bus.imem_ack) begin
          instr_d = bus.imem_data;
          state_d = ISSUE;
        end
      end

      ISSUE: begin
        // instr_q is only written in FETCH, so it is stable while stalled here.
        halt_pend_d = halt_pend_q | halt;
        if (bus.instr_ready) begin
          state_d = EXEC;
        end
      end

      EXEC: begin
        halt_pend_d = halt_pend_q | halt;
        if (bus.exec_done) begin
          pc_d           = next_pc;
          branch_taken_d = take;
          halt_pend_d    = 1'b0;
          // A halt in the same cycle as exec_done still applies to this
          // instruction; the PC is updated before stopping either way.
          if (halt_pend_q || halt) begin
            state_d = HALTED;
          end else if (run) begin
            state_d = FETCH;
          end else begin
            state_d = IDLE;
          end
        end
      end

      HALTED: begin
        // Only reset leaves HALTED.
        state_d = HALTED;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Handshake outputs decode directly from the state register, so they are
  // glitch-free and drop the cycle after the state leaves.
  assign bus.imem_req    = (state_q == FETCH);
  assign bus.imem_addr   = pc_q;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = (state_q == ISSUE);

  assign pc           = pc_q;
  assign branch_taken = branch_taken_q;
  assign halted       = (state_q == HALTED);

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       run;
  logic       halt;
  logic [7:0] pc;
  logic       branch_taken;
  logic       halted;

  int n_vec = 0;
  int n_err = 0;

  pc_sequencer_if #(.PC_WIDTH(8), .INSTR_WIDTH(16)) bus ();

  pc_sequencer #(
    .PC_WIDTH    (8),
    .INSTR_WIDTH (16),
    .RESET_PC    (0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .run          (run),
    .halt         (halt),
    .bus          (bus.master),
    .pc           (pc),
    .branch_taken (branch_taken),
    .halted       (halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic [1:0]  op;
    logic [7:0]  cmp;
    logic [7:0]  tgt;
    logic [7:0]  exp_addr;
    logic [7:0]  exp_pc;
    logic        exp_taken;
  } vec_t;

  vec_t vecs[11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Waits (bounded) for a fetch request, holds it one cycle, then acks.
  task automatic fetch(input logic [7:0] exp_addr, input logic [15:0] data);
    int n = 0;
    while (bus.imem_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("req_seen", {31'd0, bus.imem_req}, 32'd1);
    tick();
    check("req_held", {31'd0, bus.imem_req}, 32'd1);
    check("imem_addr", {24'd0, bus.imem_addr}, {24'd0, exp_addr});
    bus.imem_ack  = 1'b1;
    bus.imem_data = data;
    tick();
    bus.imem_ack  = 1'b0;
    check("req_dropped", {31'd0, bus.imem_req}, 32'd0);
    check("valid_up", {31'd0, bus.instr_valid}, 32'd1);
    check("instr", {16'd0, bus.instr}, {16'd0, data});
  endtask

  // Optionally stalls ready low for hold cycles, with an optional halt pulse.
  task automatic issue(input logic [15:0] data, input int hold, input int halt_cycle);
    for (int i = 0; i < hold; i++) begin
      if (i == halt_cycle) halt = 1'b1;
      tick();
      halt = 1'b0;
      check("stall_valid", {31'd0, bus.instr_valid}, 32'd1);
      check("stall_instr", {16'd0, bus.instr}, {16'd0, data});
    end
    bus.instr_ready = 1'b1;
    tick();
    bus.instr_ready = 1'b0;
    check("valid_in_exec", {31'd0, bus.instr_valid}, 32'd0);
  endtask

  task automatic exec(input logic [1:0] op, input logic [7:0] cmp, input logic [7:0] tgt,
                      input logic [7:0] exp_pc, input logic exp_taken);
    bus.exec_done  = 1'b1;
    bus.pc_op      = op;
    bus.cmp_res    = cmp;
    bus.jmp_target = tgt;
    tick();
    bus.exec_done = 1'b0;
    check("pc", {24'd0, pc}, {24'd0, exp_pc});
    check("branch_taken", {31'd0, branch_taken}, {31'd0, exp_taken});
    tick();
    check("branch_pulse_end", {31'd0, branch_taken}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    //            data      op    cmp    tgt    addr   pc     taken
    vecs[0]  = '{16'h1000, 2'd0, 8'h00, 8'h00, 8'h00, 8'h01, 1'b0};
    vecs[1]  = '{16'h1001, 2'd0, 8'h00, 8'h00, 8'h01, 8'h02, 1'b0};
    vecs[2]  = '{16'h1002, 2'd0, 8'h00, 8'h00, 8'h02, 8'h03, 1'b0};
    vecs[3]  = '{16'h2003, 2'd1, 8'h00, 8'h05, 8'h03, 8'h05, 1'b1};
    vecs[4]  = '{16'h2005, 2'd1, 8'h00, 8'h40, 8'h05, 8'h40, 1'b1};
    vecs[5]  = '{16'h3040, 2'd2, 8'h00, 8'h05, 8'h40, 8'h05, 1'b1};
    vecs[6]  = '{16'h3005, 2'd2, 8'h03, 8'h80, 8'h05, 8'h06, 1'b0};
    vecs[7]  = '{16'h4006, 2'd3, 8'h01, 8'hFF, 8'h06, 8'hFF, 1'b1};
    vecs[8]  = '{16'h10FF, 2'd0, 8'h00, 8'h00, 8'hFF, 8'h00, 1'b0};
    vecs[9]  = '{16'h4000, 2'd3, 8'h00, 8'h33, 8'h00, 8'h01, 1'b0};
    vecs[10] = '{16'h2001, 2'd1, 8'h00, 8'h10, 8'h01, 8'h10, 1'b1};

    rst = 1'b1; run = 1'b0; halt = 1'b0;
    bus.imem_ack = 1'b0; bus.imem_data = '0; bus.instr_ready = 1'b0;
    bus.exec_done = 1'b0; bus.pc_op = '0; bus.cmp_res = '0; bus.jmp_target = '0;
    tick();
    tick();
    check("rst_pc", {24'd0, pc}, 32'd0);
    check("rst_req", {31'd0, bus.imem_req}, 32'd0);
    check("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
    check("rst_instr", {16'd0, bus.instr}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_taken", {31'd0, branch_taken}, 32'd0);

    rst = 1'b0;
    run = 1'b1;
    for (int i = 0; i < 11; i++) begin
      fetch(vecs[i].exp_addr, vecs[i].data);
      issue(vecs[i].data, 0, -1);
      exec(vecs[i].op, vecs[i].cmp, vecs[i].tgt, vecs[i].exp_pc, vecs[i].exp_taken);
      $display("vec %0d: addr=%02h op=%0d cmp=%02h tgt=%02h -> pc=%02h taken=%0b",
               i, vecs[i].exp_addr, vecs[i].op, vecs[i].cmp, vecs[i].tgt, pc, vecs[i].exp_taken);
    end

    // Stall at pc 0x10 with halt pulsed during ISSUE.
    fetch(8'h10, 16'hBEEF);
    issue(16'hBEEF, 4, 1);
    exec(2'd0, 8'h00, 8'h00, 8'h11, 1'b0);
    check("halted_set", {31'd0, halted}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      run = ~run;
      tick();
      check("halted_req", {31'd0, bus.imem_req}, 32'd0);
      check("halted_hold", {31'd0, halted}, 32'd1);
      check("halted_pc", {24'd0, pc}, 32'h11);
    end
    $display("halt seq: pc=%02h halted=%0b", pc, halted);
    run = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("unhalt_pc", {24'd0, pc}, 32'd0);
    check("unhalt_halted", {31'd0, halted}, 32'd0);

    // Reset while a fetch at 0x22 is outstanding; the late ack is ignored.
    run = 1'b1;
    fetch(8'h00, 16'h2222);
    issue(16'h2222, 0, -1);
    exec(2'd1, 8'h00, 8'h22, 8'h22, 1'b1);
    fetch_wait_check();
    rst = 1'b1;
    run = 1'b0;
    tick();
    rst = 1'b0;
    bus.imem_ack  = 1'b1;
    bus.imem_data = 16'hDEAD;
    tick();
    bus.imem_ack = 1'b0;
    check("late_ack_pc", {24'd0, pc}, 32'd0);
    check("late_ack_instr", {16'd0, bus.instr}, 32'd0);
    check("late_ack_req", {31'd0, bus.imem_req}, 32'd0);
    check("late_ack_valid", {31'd0, bus.instr_valid}, 32'd0);
    check("late_ack_halted", {31'd0, halted}, 32'd0);
    bus.exec_done  = 1'b1;
    bus.pc_op      = 2'd1;
    bus.jmp_target = 8'h77;
    tick();
    bus.exec_done = 1'b0;
    check("late_done_pc", {24'd0, pc}, 32'd0);
    check("late_done_taken", {31'd0, branch_taken}, 32'd0);
    $display("reset seq: pc=%02h instr=%04h", pc, bus.instr);

    // Halt in IDLE goes straight to HALTED; run is then ignored.
    halt = 1'b1;
    tick();
    halt = 1'b0;
    check("idle_halt", {31'd0, halted}, 32'd1);
    run = 1'b1;
    tick();
    tick();
    check("idle_halt_req", {31'd0, bus.imem_req}, 32'd0);
    check("idle_halt_hold", {31'd0, halted}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Waits for the pending request at 0x22 without acknowledging it.
  task automatic fetch_wait_check();
    int n = 0;
    while (bus.imem_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("pend_req", {31'd0, bus.imem_req}, 32'd1);
    check("pend_addr", {24'd0, bus.imem_addr}, 32'h22);
  endtask

endmodule
